// File: rtl/pipe_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned chunk_w(input int unsigned n, input int unsigned stages);
    return (stages == 0) ? 0 : n / stages;
  endfunction

  function automatic bit params_ok(input int unsigned n, input int unsigned stages);
    return (stages >= 1) && (n >= 1) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit slice of the carry chain: sum, carry-out and carry into the slice MSB.
module adder_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign sum   = full[W-1:0];
  assign cout  = full[W];
  // Carry into bit W-1 recovered from the MSB sum bit, valid for any W >= 1.
  assign c_msb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined N-bit add/subtract with valid/ready handshake; carry chain split into STAGES chunks.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow,
  output logic         zero
);

  localparam int unsigned CHUNK = chunk_w(N, STAGES);

  if (!params_ok(N, STAGES)) begin : g_param_check
    $fatal(1, "pipe_adder: N=%0d must be a nonzero multiple of STAGES=%0d", N, STAGES);
  end

  logic         en;
  op_e          op;
  logic [N-1:0] b_eff;
  logic         c0;

  // Stage registers
  logic         vld_q [STAGES];
  logic [N-1:0] opa_q [STAGES];
  logic [N-1:0] opb_q [STAGES];
  logic [N-1:0] acc_q [STAGES];
  logic         cy_q  [STAGES];
  logic         zr_q  [STAGES];
  logic         ovf_q;

  // Per-stage inputs and chunk results
  logic             src_v   [STAGES];
  logic [N-1:0]     src_a   [STAGES];
  logic [N-1:0]     src_b   [STAGES];
  logic [N-1:0]     src_acc [STAGES];
  logic             src_c   [STAGES];
  logic             src_z   [STAGES];
  logic [N-1:0]     acc_n   [STAGES];
  logic [CHUNK-1:0] ch_sum  [STAGES];
  logic             ch_cout [STAGES];
  logic             ch_cmsb [STAGES];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign op       = op_e'(sub);

  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    c0    = (op == OP_SUB) ? ~cin : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_v[k]   = in_valid;
      assign src_a[k]   = a;
      assign src_b[k]   = b_eff;
      assign src_c[k]   = c0;
      assign src_acc[k] = '0;
      assign src_z[k]   = 1'b1;
    end else begin : g_link
      assign src_v[k]   = vld_q[k-1];
      assign src_a[k]   = opa_q[k-1];
      assign src_b[k]   = opb_q[k-1];
      assign src_c[k]   = cy_q[k-1];
      assign src_acc[k] = acc_q[k-1];
      assign src_z[k]   = zr_q[k-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a     (src_a[k][k*CHUNK +: CHUNK]),
      .b     (src_b[k][k*CHUNK +: CHUNK]),
      .cin   (src_c[k]),
      .sum   (ch_sum[k]),
      .cout  (ch_cout[k]),
      .c_msb (ch_cmsb[k])
    );

    // Deskew: completed lower chunks ride along, this stage fills in its own slice.
    always_comb begin
      acc_n[k] = src_acc[k];
      acc_n[k][k*CHUNK +: CHUNK] = ch_sum[k];
    end

    // Data only loads with a valid beat so bubbles leave the last result on the outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[k] <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        acc_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        zr_q[k]  <= 1'b0;
      end else if (en) begin
        vld_q[k] <= src_v[k];
        if (src_v[k]) begin
          opa_q[k] <= src_a[k];
          opb_q[k] <= src_b[k];
          acc_q[k] <= acc_n[k];
          cy_q[k]  <= ch_cout[k];
          zr_q[k]  <= src_z[k] && (ch_sum[k] == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en && src_v[STAGES-1]) begin
      ovf_q <= ch_cmsb[STAGES-1] ^ ch_cout[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign carry     = cy_q[STAGES-1];
  assign zero      = zr_q[STAGES-1];
  assign overflow  = ovf_q;

  always @(posedge clk) begin
    if (!rst) begin
      assert (in_ready == (!out_valid || out_ready));
      if (!$past(rst) && $past(out_valid && !out_ready))
        assert (out_valid && (sum == $past(sum)) && (carry == $past(carry)) &&
                (overflow == $past(overflow)) && (zero == $past(zero)));
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and streaming bench for pipe_adder at (8,2), plus stall streams at (8,2), (32,4), (8,1).
module tb_pipe_adder;

  localparam int unsigned N0 = 8;
  localparam int unsigned S0 = 2;
  localparam int unsigned SN [3] = '{8, 32, 8};
  localparam int unsigned SS [3] = '{2, 4, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Golden: {zero, overflow, carry, sum} from one wide add and the sign rule.
  function automatic logic [34:0] gold(input int unsigned n, input logic [31:0] ga,
                                       input logic [31:0] gb, input logic gc, input logic gs);
    logic [63:0] mask, aa, bb, full;
    logic [31:0] s;
    logic        c, o;
    mask = (64'd1 << n) - 64'd1;
    aa   = {32'd0, ga} & mask;
    bb   = {32'd0, (gs ? ~gb : gb)} & mask;
    full = aa + bb + {63'd0, (gs ? ~gc : gc)};
    s    = full[31:0] & mask[31:0];
    c    = full[n];
    o    = (aa[n-1] == bb[n-1]) && (s[n-1] != aa[n-1]);
    return {(s == 32'd0), o, c, s};
  endfunction

  // ---------------- main DUT (8,2) ----------------
  logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic          carry, overflow, zero;
  logic [N0-1:0] a, b, sum;

  pipe_adder #(.N(N0), .STAGES(S0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
  );

  logic [34:0] q0 [$];
  int unsigned recv0 = 0;

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
    end else begin
      check("dut0_in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (q0.size() == 0) check("dut0_spurious", out_valid, 1'b0);
        else begin
          check("dut0_stream", {zero, overflow, carry, 32'(sum)}, q0.pop_front());
          recv0 <= recv0 + 1;
        end
      end
      if (in_valid && in_ready) q0.push_back(gold(N0, 32'(a), 32'(b), cin, sub));
    end
  end

  task automatic do_beat(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                         input logic tc, input logic ts, input logic [7:0] es,
                         input logic ec, input logic eo, input logic ez);
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < S0; i++) begin
      @(negedge clk);
      check({tag, "_early"}, out_valid, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"},   sum,       es);
    check({tag, "_carry"}, carry,     ec);
    check({tag, "_ovf"},   overflow,  eo);
    check({tag, "_zero"},  zero,      ez);
    @(posedge clk); #1;
  endtask

  // ---------------- stall streams at three configurations ----------------
  logic rst_s;
  initial begin
    rst_s = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_s = 1'b0;
  end

  for (genvar g = 0; g < 3; g++) begin : g_st
    localparam int unsigned NN  = SN[g];
    localparam int unsigned SSG = SS[g];

    logic          iv, ir, ov, orr, ci, sb, c, o, z;
    logic [NN-1:0] av, bv, sm;
    logic [34:0]   q [$];
    int unsigned   recv = 0;
    logic          stall = 1'b0;
    logic [NN+3:0] held = '0;

    pipe_adder #(.N(NN), .STAGES(SSG)) u_dut (
      .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir),
      .a(av), .b(bv), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(orr),
      .sum(sm), .carry(c), .overflow(o), .zero(z)
    );

    initial begin : drive
      int unsigned sent;
      logic [31:0] t;
      sent = 0;
      iv = 1'b0; orr = 1'b1; av = '0; bv = '0; ci = 1'b0; sb = 1'b0;
      wait (rst_s == 1'b0);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        iv = (sent < 20);
        t  = (sent * 32'h9E3779B1) ^ 32'h5A5A_1234;
        av = t[NN-1:0];
        t  = (sent * 32'h7F4A7C15) ^ {sent[7:0], 24'h00_0F_F0};
        bv = t[NN-1:0];
        ci = sent[0];
        sb = sent[1];
        orr = !(cyc >= 8 && cyc < 11);
        @(negedge clk);
        if (iv && ir) sent++;
        @(posedge clk); #1;
      end
      check($sformatf("st%0d_sent", g), sent, 20);
      check($sformatf("st%0d_recv", g), recv, 20);
      check($sformatf("st%0d_left", g), q.size(), 0);
    end

    always @(negedge clk) begin
      if (rst_s) begin
        q.delete();
      end else begin
        check($sformatf("st%0d_in_ready", g), ir, !ov || orr);
        if (stall) check($sformatf("st%0d_hold", g), {ov, z, o, c, sm}, held);
        if (ov && orr) begin
          if (q.size() == 0) check($sformatf("st%0d_spurious", g), ov, 1'b0);
          else begin
            check($sformatf("st%0d_data", g), {z, o, c, 32'(sm)}, q.pop_front());
            recv <= recv + 1;
          end
        end
        if (iv && ir) q.push_back(gold(NN, 32'(av), 32'(bv), ci, sb));
        stall <= ov && !orr;
        held  <= {ov, z, o, c, sm};
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "tb_pipe_adder timeout");
  end

  initial begin : main
    int unsigned base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_sum",   sum,       8'h00);
    check("rst_carry", carry,     1'b0);
    check("rst_ovf",   overflow,  1'b0);
    check("rst_zero",  zero,      1'b0);
    check("rst_ready", in_ready,  1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    do_beat("t1",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    do_beat("t2a", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    do_beat("t2b", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    do_beat("t3a", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    do_beat("t3b", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    do_beat("t3c", 8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
    do_beat("t3d", 8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    base = recv0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (S0 + 1) @(posedge clk); #1;
    check("t4_count",   recv0 - base, 1000);
    check("t4_drained", q0.size(),    0);

    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_sum",   sum,       8'h00);
    check("t6_rst_carry", carry,     1'b0);
    check("t6_rst_ovf",   overflow,  1'b0);
    check("t6_rst_zero",  zero,      1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_in_ready", in_ready, 1'b1);
    do_beat("t6", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
